// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Handshake: start is sampled only at an edge where busy=0 (state IDLE); the core holds start until then.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             unsign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       o_dbg_state
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] OP_MULT = 2'd0;
    localparam logic [1:0] OP_DIV  = 2'd1;
    localparam logic [1:0] OP_MTHI = 2'd2;
    localparam logic [1:0] OP_MTLO = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [CW-1:0]      r_cnt;
    logic               r_is_div;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic               r_dbz;
    logic               r_done;
    logic [WIDTH-1:0]   r_a_raw;
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_accept;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;

    logic [WIDTH-1:0]   w_add;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;

    logic [WIDTH:0]     w_rem_sh;
    logic               w_qbit;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_rem_new;
    logic [2*WIDTH-1:0] w_div_next;

    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_accept = (r_state == S_IDLE) && start && !flush;

    // Magnitudes are unsigned WIDTH-bit values, so -(most negative) is exact.
    assign w_a_neg = !unsign && a[WIDTH-1];
    assign w_b_neg = !unsign && b[WIDTH-1];
    assign w_a_mag = w_a_neg ? -a : a;
    assign w_b_mag = w_b_neg ? -b : b;

    // Shift-add multiply: multiplier sits in the low half, consumed LSB first.
    assign w_add      = r_acc[0] ? r_mcand : '0;
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_add};
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring divide: remainder in the high half, dividend/quotient in the low half.
    assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_qbit     = (w_rem_sh >= {1'b0, r_mcand});
    assign w_diff     = w_rem_sh[WIDTH-1:0] - r_mcand;
    assign w_rem_new  = w_qbit ? w_diff : w_rem_sh[WIDTH-1:0];
    assign w_div_next = {w_rem_new, r_acc[WIDTH-2:0], w_qbit};

    assign w_prod = r_neg_res ? -r_acc : r_acc;
    assign w_quo  = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && (op == OP_MULT || op == OP_DIV)) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (flush) begin
                    w_next = S_IDLE;
                end else if (r_cnt == CW'(WIDTH - 1)) begin
                    w_next = S_FIX;
                end
            end
            S_FIX: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_dbz     <= 1'b0;
            r_done    <= 1'b0;
            r_a_raw   <= '0;
            r_mcand   <= '0;
            r_acc     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        case (op)
                            OP_MTHI: r_hi <= a;
                            OP_MTLO: r_lo <= a;
                            default: begin
                                r_is_div  <= (op == OP_DIV);
                                r_neg_res <= w_a_neg ^ w_b_neg;
                                r_neg_rem <= w_a_neg;
                                r_dbz     <= (b == '0);
                                r_a_raw   <= a;
                                r_cnt     <= '0;
                                if (op == OP_DIV) begin
                                    r_mcand <= w_b_mag;
                                    r_acc   <= {{WIDTH{1'b0}}, w_a_mag};
                                end else begin
                                    r_mcand <= w_a_mag;
                                    r_acc   <= {{WIDTH{1'b0}}, w_b_mag};
                                end
                            end
                        endcase
                    end
                end
                S_RUN: begin
                    if (!flush) begin
                        r_acc <= r_is_div ? w_div_next : w_mul_next;
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_FIX: begin
                    if (!flush) begin
                        r_done <= 1'b1;
                        if (!r_is_div) begin
                            r_hi <= w_prod[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod[WIDTH-1:0];
                        end else if (r_dbz) begin
                            r_hi <= r_a_raw;
                            r_lo <= '1;
                        end else begin
                            r_hi <= w_rem;
                            r_lo <= w_quo;
                        end
                    end
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a 32-bit instance for most vectors and an 8-bit instance for width scaling.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic [1:0]  op;
    logic        unsign;

    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  dbg_state;

    logic        start8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        busy8;
    logic        done8;
    logic [7:0]  hi8;
    logic [7:0]  lo8;
    logic [1:0]  dbg_state8;

    int n_vec = 0;
    int n_bad = 0;

    muldiv_unit #(.WIDTH(32)) u_dut32 (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .op          (op),
        .unsign      (unsign),
        .a           (a),
        .b           (b),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .o_dbg_state (dbg_state)
    );

    muldiv_unit #(.WIDTH(8)) u_dut8 (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start8),
        .op          (op),
        .unsign      (unsign),
        .a           (a8),
        .b           (b8),
        .flush       (flush),
        .busy        (busy8),
        .done        (done8),
        .hi          (hi8),
        .lo          (lo8),
        .o_dbg_state (dbg_state8)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // All tasks are entered and left at a falling edge.
    task automatic start_op(input logic [1:0] o, input logic u, input logic [31:0] x, input logic [31:0] y);
        start  = 1'b1;
        op     = o;
        unsign = u;
        a      = x;
        b      = y;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic do_md(input string tag, input logic [1:0] o, input logic u,
                         input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        start_op(o, u, x, y);
        wait_done(n);
        check({tag, " busy cycles"}, 64'(n), 64'd33);
        check({tag, " done"}, 64'(done), 64'd1);
        check({tag, " hi"}, 64'(hi), 64'(exp_hi));
        check({tag, " lo"}, 64'(lo), 64'(exp_lo));
    endtask

    task automatic do_md8(input string tag, input logic [1:0] o, input logic u,
                          input logic [7:0] x, input logic [7:0] y,
                          input logic [7:0] exp_hi, input logic [7:0] exp_lo);
        int n;
        start8 = 1'b1;
        op     = o;
        unsign = u;
        a8     = x;
        b8     = y;
        @(negedge clk);
        start8 = 1'b0;
        n = 0;
        while (busy8 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check({tag, " busy cycles"}, 64'(n), 64'd9);
        check({tag, " done"}, 64'(done8), 64'd1);
        check({tag, " hi"}, 64'(hi8), 64'(exp_hi));
        check({tag, " lo"}, 64'(lo8), 64'(exp_lo));
    endtask

    initial begin
        int  n;
        bit  saw_done;

        reset_n = 1'b0;
        flush   = 1'b0;
        start   = 1'b0;
        start8  = 1'b0;
        op      = 2'd0;
        unsign  = 1'b0;
        a       = '0;
        b       = '0;
        a8      = '0;
        b8      = '0;
        repeat (3) @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        check("reset state", 64'(dbg_state), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Multiplies; the second is issued in the done cycle of the first.
        do_md("smul -3*7", 2'd0, 1'b0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        do_md("umul max*max b2b", 2'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        @(negedge clk);
        check("done pulse width", 64'(done), 64'd0);
        do_md("smul min*min", 2'd0, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        do_md("smul min*1", 2'd0, 1'b0, 32'h8000_0000, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000);

        // Divides.
        do_md("sdiv -7/2", 2'd1, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_md("udiv -7/2", 2'd1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC);
        do_md("sdiv min/-1", 2'd1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        do_md("sdiv 7/-2", 2'd1, 1'b0, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        do_md("udiv 100/7", 2'd1, 1'b1, 32'd100, 32'd7, 32'd2, 32'd14);
        do_md("udiv by zero", 2'd1, 1'b1, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF);
        do_md("sdiv by zero", 2'd1, 1'b0, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF);
        do_md("sdiv neg by zero", 2'd1, 1'b0, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        @(negedge clk);

        // MTHI/MTLO, then a multiply that must hold hi until its FIX edge.
        start_op(2'd2, 1'b0, 32'h0000_00AA, 32'd0);
        check("mthi busy", 64'(busy), 64'd0);
        check("mthi done", 64'(done), 64'd0);
        check("mthi hi", 64'(hi), 64'h0000_00AA);
        start_op(2'd3, 1'b0, 32'h0000_0011, 32'd0);
        check("mtlo lo", 64'(lo), 64'h0000_0011);
        check("mtlo keeps hi", 64'(hi), 64'h0000_00AA);
        start_op(2'd0, 1'b0, 32'd2, 32'd3);
        repeat (3) @(negedge clk);
        start_op(2'd3, 1'b0, 32'h0000_0055, 32'd0);
        check("busy mtlo ignored lo", 64'(lo), 64'h0000_0011);
        start_op(2'd2, 1'b0, 32'h0000_0066, 32'd0);
        check("busy mthi ignored hi", 64'(hi), 64'h0000_00AA);
        wait_done(n);
        check("mul 2*3 done", 64'(done), 64'd1);
        check("mul 2*3 hi", 64'(hi), 64'd0);
        check("mul 2*3 lo", 64'(lo), 64'd6);
        repeat (2) @(negedge clk);
        check("mul 2*3 lo holds", 64'(lo), 64'd6);

        // Flush on RUN cycle 10.
        start_op(2'd1, 1'b1, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        check("pre-flush state run", 64'(dbg_state), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush run busy", 64'(busy), 64'd0);
        check("flush run done", 64'(done), 64'd0);
        check("flush run hi", 64'(hi), 64'd0);
        check("flush run lo", 64'(lo), 64'd6);
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("flush run no late done", 64'(saw_done), 64'd0);

        // Flush landing on the FIX edge.
        start_op(2'd0, 1'b0, 32'd5, 32'd5);
        repeat (32) @(negedge clk);
        check("pre-flush state fix", 64'(dbg_state), 64'd2);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush fix busy", 64'(busy), 64'd0);
        check("flush fix done", 64'(done), 64'd0);
        check("flush fix lo", 64'(lo), 64'd6);

        // Flush and start together in IDLE: start is dropped.
        flush = 1'b1;
        start_op(2'd0, 1'b0, 32'd5, 32'd5);
        flush = 1'b0;
        check("flush+start busy", 64'(busy), 64'd0);
        flush = 1'b1;
        start_op(2'd2, 1'b0, 32'h0000_0077, 32'd0);
        flush = 1'b0;
        check("flush+mthi hi", 64'(hi), 64'd0);

        // Reset in the middle of a run.
        start_op(2'd0, 1'b0, 32'd9, 32'd9);
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("midrun reset busy", 64'(busy), 64'd0);
        check("midrun reset hi", 64'(hi), 64'd0);
        check("midrun reset lo", 64'(lo), 64'd0);
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("midrun reset no done", 64'(saw_done), 64'd0);

        // 8-bit instance.
        do_md8("w8 smul -128*-1", 2'd0, 1'b0, 8'h80, 8'hFF, 8'h00, 8'h80);
        do_md8("w8 smul -3*7", 2'd0, 1'b0, 8'hFD, 8'h07, 8'hFF, 8'hEB);
        do_md8("w8 sdiv min/-1", 2'd1, 1'b0, 8'h80, 8'hFF, 8'h00, 8'h80);
        do_md8("w8 udiv 200/9", 2'd1, 1'b1, 8'd200, 8'd9, 8'd2, 8'd22);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
